uart_transmitter: RTL

//  8N1 UART transmitter; the transmit side of the UART link, counterpart of the UART receiver.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_transmitter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM states and framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int UART_CLKS_9600_AT_12MHZ = 1250;
  localparam int UART_DATA_BITS          = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: tick is high in the last cycle of each bit period, then it reloads.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_9600_AT_12MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load || (en && (timer_q == '0))) begin
      timer_d = RELOAD;
    end else if (en) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign tick = (timer_q == '0);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register so consecutive frames leave back-to-back.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_9600_AT_12MHZ,
  parameter int STOP_BITS    = 1
) (
  input  logic                      clock_12MHz,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] data,
  input  logic                      data_valid,
  output logic                      ready,
  output logic                      busy,
  output logic                      uart_tx
);

  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] hold_q, hold_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      hold_full_q, hold_full_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      tx_q, tx_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      timer_load;
  logic                      tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clock_12MHz),
    .rst (reset),
    .load(timer_load),
    .en  (state_q != IDLE),
    .tick(tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    timer_load  = 1'b0;

    // ready_q is only high while the hold is empty, so accept and load never coincide.
    if (data_valid && ready_q) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          timer_load  = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        // bit_cnt counts stop bits here; a waiting byte starts its frame on the same edge.
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              timer_load  = 1'b1;
              state_d     = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = !hold_full_d;
    busy_d  = (state_q != IDLE) || hold_full_q;

    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock_12MHz) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clock_12MHz) begin
    hold_q  <= hold_d;
    shift_q <= shift_d;
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign uart_tx = tx_q;

endmodule
